// File: rtl/cpu0_pkg.sv
// rtl/cpu0_pkg.sv - shared stack geometry constants and width helpers
package cpu0_pkg;

    localparam int                DEF_STACK_WIDTH = 16;
    localparam int                DEF_STACK_DEPTH = 8;
    localparam int                DEF_ADDR_W      = 16;
    localparam logic [15:0]       DEF_BASE_ADDR   = 16'hFFFF;

    // Count must represent 0..DEPTH inclusive, hence depth+1.
    function automatic int stack_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int stack_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hw_stack_mem.sv
// rtl/hw_stack_mem.sv - DEPTHxWIDTH register array, one write port, async read
module hw_stack_mem
    import cpu0_pkg::*;
#(
    parameter int WIDTH = DEF_STACK_WIDTH,
    parameter int DEPTH = DEF_STACK_DEPTH,
    parameter int AW    = stack_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/hw_stack.sv
// rtl/hw_stack.sv - hardware stack with occupancy, stack address and sticky error flags
module hw_stack
    import cpu0_pkg::*;
#(
    parameter int                WIDTH     = DEF_STACK_WIDTH,
    parameter int                DEPTH     = DEF_STACK_DEPTH,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter int                AFULL_LVL = DEPTH - 1,
    localparam int               CW        = stack_cw(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_err,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  dout,
    output logic [CW-1:0]     count,
    output logic [ADDR_W-1:0] sp_addr,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              ovf,
    output logic              udf
);

    localparam int          AW      = stack_aw(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_udf;

    logic [CW-1:0]    w_count_nxt;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_rdata;
    logic             w_empty;
    logic             w_full;
    logic             w_ovf_set;
    logic             w_udf_set;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_top_idx = AW'(r_count - CW'(1));

    always_comb begin
        w_count_nxt = r_count;
        w_we        = 1'b0;
        w_waddr     = w_top_idx;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
        if (flush) begin
            w_count_nxt = '0;
        end else if (push && pop) begin
            // Simultaneous push/pop replaces the top; on an empty stack it is a plain push.
            w_we = 1'b1;
            if (w_empty) begin
                w_waddr     = '0;
                w_count_nxt = CW'(1);
            end
        end else if (push) begin
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_we        = 1'b1;
                w_waddr     = AW'(r_count);
                w_count_nxt = r_count + CW'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                w_udf_set = 1'b1;
            end else begin
                w_count_nxt = r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_set | (r_ovf & ~clr_err);
            r_udf   <= w_udf_set | (r_udf & ~clr_err);
        end
    end

    hw_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (din),
        .raddr (w_top_idx),
        .rdata (w_rdata)
    );

    assign dout        = w_empty ? '0 : w_rdata;
    assign count       = r_count;
    assign sp_addr     = BASE_ADDR - ADDR_W'(r_count);
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= AFULL_C);
    assign ovf         = r_ovf;
    assign udf         = r_udf;

    a_ctrl_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(push) && !$isunknown(pop))
        else $error("hw_stack: push/pop unknown");

    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        r_count <= DEPTH_C)
        else $error("hw_stack: count exceeds DEPTH");

endmodule
